// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - icache/dcache/memory signal bundle around the memory arbiter
interface mem_arbiter_if;
    logic        ic_req;
    logic [29:0] ic_addr;
    logic        ic_abort;
    logic        ic_gnt;
    logic        ic_rvalid;
    logic        ic_rlast;
    logic [31:0] ic_rdata;

    logic        dc_req;
    logic        dc_we;
    logic [29:0] dc_addr;
    logic [31:0] dc_wdata;
    logic        dc_gnt;
    logic        dc_wready;
    logic        dc_wdone;
    logic        dc_rvalid;
    logic        dc_rlast;
    logic [31:0] dc_rdata;

    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_wvalid;
    logic [31:0] mem_wdata;
    logic        mem_wready;

    // master: the arbiter, which drives the memory burst port
    modport master (
        input  ic_req, ic_addr, ic_abort,
        input  dc_req, dc_we, dc_addr, dc_wdata,
        input  mem_ready, mem_rvalid, mem_rdata, mem_wready,
        output ic_gnt, ic_rvalid, ic_rlast, ic_rdata,
        output dc_gnt, dc_wready, dc_wdone, dc_rvalid, dc_rlast, dc_rdata,
        output mem_req, mem_we, mem_addr, mem_wvalid, mem_wdata
    );

    // slave: the caches plus the memory, seen from outside the arbiter
    modport slave (
        output ic_req, ic_addr, ic_abort,
        output dc_req, dc_we, dc_addr, dc_wdata,
        output mem_ready, mem_rvalid, mem_rdata, mem_wready,
        input  ic_gnt, ic_rvalid, ic_rlast, ic_rdata,
        input  dc_gnt, dc_wready, dc_wdone, dc_rvalid, dc_rlast, dc_rdata,
        input  mem_req, mem_we, mem_addr, mem_wvalid, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin line-burst arbiter between icache and dcache
module mem_arbiter #(
    parameter int LINE_WORDS = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.master bus
);
    localparam int              CW         = $clog2(LINE_WORDS);
    localparam logic [CW-1:0]   LAST       = CW'(LINE_WORDS - 1);
    localparam logic [29:0]     ALIGN_MASK = ~30'(LINE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, REQ, RDATA, WDATA} state_t;

    state_t          state, state_nxt;
    logic            owner_dc;
    logic            we_q;
    logic [29:0]     addr_q;
    logic [CW-1:0]   cnt;
    logic            abort_flag;
    logic            rr_dc;
    logic            ic_gnt_q, dc_gnt_q, wdone_q;

    logic            any_req, win_dc, beat, last_beat;

    assign any_req   = bus.ic_req | bus.dc_req;
    // on a tie the side that was not served last wins
    assign win_dc    = bus.dc_req & (~bus.ic_req | ~rr_dc);
    assign beat      = ((state == RDATA) & bus.mem_rvalid) | ((state == WDATA) & bus.mem_wready);
    assign last_beat = beat & (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = REQ;
            REQ:     if (bus.mem_ready) state_nxt = we_q ? WDATA : RDATA;
            RDATA,
            WDATA:   if (last_beat) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_dc   <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            cnt        <= '0;
            abort_flag <= 1'b0;
            rr_dc      <= 1'b1;
            ic_gnt_q   <= 1'b0;
            dc_gnt_q   <= 1'b0;
            wdone_q    <= 1'b0;
        end else begin
            ic_gnt_q <= 1'b0;
            dc_gnt_q <= 1'b0;
            wdone_q  <= 1'b0;
            case (state)
                IDLE: begin
                    abort_flag <= 1'b0;
                    if (any_req) begin
                        owner_dc <= win_dc;
                        we_q     <= win_dc & bus.dc_we;
                        addr_q   <= (win_dc ? bus.dc_addr : bus.ic_addr) & ALIGN_MASK;
                        rr_dc    <= win_dc;
                        ic_gnt_q <= ~win_dc;
                        dc_gnt_q <= win_dc;
                    end
                end
                // abort only hides beats; the memory burst still runs to completion
                REQ, RDATA: if (!owner_dc && bus.ic_abort) abort_flag <= 1'b1;
                default: ;
            endcase
            if (beat) cnt <= cnt + 1'b1;
            if (last_beat && state == WDATA) wdone_q <= 1'b1;
        end
    end

    always_comb begin
        bus.ic_gnt     = ic_gnt_q;
        bus.dc_gnt     = dc_gnt_q;
        bus.dc_wdone   = wdone_q;
        bus.ic_rvalid  = 1'b0;
        bus.ic_rlast   = 1'b0;
        bus.ic_rdata   = '0;
        bus.dc_rvalid  = 1'b0;
        bus.dc_rlast   = 1'b0;
        bus.dc_rdata   = '0;
        bus.dc_wready  = 1'b0;
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wvalid = 1'b0;
        bus.mem_wdata  = '0;
        case (state)
            REQ: begin
                bus.mem_req  = 1'b1;
                bus.mem_we   = we_q;
                bus.mem_addr = addr_q;
            end
            RDATA: begin
                if (owner_dc) begin
                    bus.dc_rvalid = bus.mem_rvalid;
                    bus.dc_rlast  = bus.mem_rvalid & (cnt == LAST);
                    bus.dc_rdata  = bus.mem_rdata;
                end else begin
                    bus.ic_rvalid = bus.mem_rvalid & ~abort_flag;
                    bus.ic_rlast  = bus.mem_rvalid & ~abort_flag & (cnt == LAST);
                    bus.ic_rdata  = bus.mem_rdata;
                end
            end
            WDATA: begin
                bus.mem_wvalid = 1'b1;
                bus.mem_wdata  = bus.dc_wdata;
                bus.dc_wready  = bus.mem_wready;
            end
            default: ;
        endcase
    end
endmodule
